// File: rtl/sna_pkg.sv
// Shared SNA constants: VC/flit defaults, arbiter state encoding, flit control bit positions.
package sna_pkg;

  localparam int SNA_NUM_VC = 8;
  localparam int SNA_FLIT_W = 36;

  // 32-bit payload, control bits above it
  localparam int SNA_FLIT_HEAD_BIT = 32;
  localparam int SNA_FLIT_TAIL_BIT = 33;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } sna_arb_state_e;

endpackage

// File: rtl/sna_rr_picker.sv
// Rotating-priority picker: first set request at or above ptr_i, with wrap-around.
module sna_rr_picker #(
  parameter int NUM_VC = 8,
  parameter int VC_W   = 3
) (
  input  logic [NUM_VC-1:0] req_i,
  input  logic [VC_W-1:0]   ptr_i,
  output logic [VC_W-1:0]   idx_o,
  output logic              any_o
);

  logic [VC_W-1:0] cand;

  // Walk offsets from highest to lowest so the smallest offset wins; NUM_VC is a power of two so VC_W arithmetic wraps.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      cand = ptr_i + VC_W'(i);
      if (req_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sna_request_vc_arbiter.sv
// Round-robin VC arbiter holding a grant for a whole packet in front of the SNA request transmitter.
// Optional stall watchdog compiled in with SNA_VC_ARB_WATCHDOG_EN.
module sna_request_vc_arbiter
  import sna_pkg::*;
#(
  parameter int NUM_VC      = SNA_NUM_VC,
  parameter int FLIT_W      = SNA_FLIT_W,
  parameter int VC_W        = $clog2(NUM_VC),
  parameter int WDOG_CYCLES = 255
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [NUM_VC-1:0]        vc_flit_valid,
  input  logic [NUM_VC-1:0]        vc_flit_head,
  input  logic [NUM_VC-1:0]        vc_flit_tail,
  input  logic [NUM_VC*FLIT_W-1:0] vc_flit_data,
  output logic [NUM_VC-1:0]        vc_pop,
  input  logic                     tx_allocatable,
  input  logic                     tx_ready,
  output logic                     tx_valid,
  output logic [FLIT_W-1:0]        tx_flit,
  output logic                     tx_tail,
  output logic                     grant_active,
  output logic [VC_W-1:0]          grant_vc,
  output logic                     wdog_abort
);

  sna_arb_state_e state_q, state_d;
  logic [VC_W-1:0] grant_vc_q, grant_vc_d;
  logic [VC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [VC_W-1:0] pick_idx;
  logic            pick_any;
  logic [NUM_VC-1:0] eligible;
  logic [NUM_VC-1:0][FLIT_W-1:0] flit_arr;
  logic granted, xfer, wdog_fire;

  assign flit_arr = vc_flit_data;
  assign eligible = vc_flit_valid & vc_flit_head;

  sna_rr_picker #(.NUM_VC(NUM_VC), .VC_W(VC_W)) u_picker (
    .req_i (eligible),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign granted      = (state_q == ST_GRANT);
  assign tx_valid     = granted & vc_flit_valid[grant_vc_q];
  assign tx_tail      = granted & vc_flit_tail[grant_vc_q];
  assign tx_flit      = granted ? flit_arr[grant_vc_q] : '0;
  assign xfer         = tx_valid & tx_ready;
  assign grant_active = granted;
  assign grant_vc     = grant_vc_q;

  always_comb begin
    vc_pop = '0;
    if (xfer) vc_pop[grant_vc_q] = 1'b1;
  end

`ifdef SNA_VC_ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_abort_q;

  // Fires on the stall cycle that brings the count to WDOG_CYCLES; release and pulse land together next cycle.
  assign wdog_fire = granted & ~xfer & (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
    if (!granted || xfer) wdog_cnt_d = '0;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q   <= '0;
      wdog_abort_q <= 1'b0;
    end else begin
      wdog_cnt_q   <= wdog_cnt_d;
      wdog_abort_q <= wdog_fire;
    end
  end

  assign wdog_abort = wdog_abort_q;
`else
  assign wdog_fire  = 1'b0;
  assign wdog_abort = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_vc_d = grant_vc_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_allocatable && pick_any) begin
          state_d    = ST_GRANT;
          grant_vc_d = pick_idx;
        end
      end
      ST_GRANT: begin
        if ((xfer && tx_tail) || wdog_fire) begin
          state_d  = ST_IDLE;
          rr_ptr_d = grant_vc_q + VC_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_vc_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_vc_q <= grant_vc_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_sna_request_vc_arbiter.sv
// Bench for sna_request_vc_arbiter: reset/pick table, directed packet sequences, randomized traffic vs queue model.
module tb_sna_request_vc_arbiter;

  localparam int NV = 8;
  localparam int FW = 36;
  localparam int VW = 3;
  localparam int WD = 8;

  logic clock = 1'b0;
  logic rst_n;
  logic [NV-1:0]    vc_flit_valid, vc_flit_head, vc_flit_tail, vc_pop;
  logic [NV*FW-1:0] vc_flit_data;
  logic             tx_allocatable, tx_ready, tx_valid, tx_tail, grant_active, wdog_abort;
  logic [FW-1:0]    tx_flit;
  logic [VW-1:0]    grant_vc;

  always #5 clock = ~clock;

  sna_request_vc_arbiter #(.NUM_VC(NV), .FLIT_W(FW), .VC_W(VW), .WDOG_CYCLES(WD)) dut (
    .clock(clock), .rst_n(rst_n),
    .vc_flit_valid(vc_flit_valid), .vc_flit_head(vc_flit_head), .vc_flit_tail(vc_flit_tail),
    .vc_flit_data(vc_flit_data), .vc_pop(vc_pop),
    .tx_allocatable(tx_allocatable), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_flit(tx_flit), .tx_tail(tx_tail),
    .grant_active(grant_active), .grant_vc(grant_vc), .wdog_abort(wdog_abort)
  );

  typedef struct { logic [FW-1:0] d; bit h; bit t; } flit_t;
  typedef struct { logic [NV-1:0] v; logic [NV-1:0] h; bit alloc; bit e_act; int e_vc; } vec_t;

  flit_t fq[NV][$];
  bit    bub[NV];
  int    n_chk, n_fail;
  // reference model: granted flag, granted VC, priority pointer, stall count, pending abort pulse
  bit    m_grant, m_abort;
  int    m_gvc, m_ptr, m_stall;
  int    grants[$];
  bit    prev_ga;
  int    pops_seen[NV];
  int    aborts_seen;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gnt(input int k);
    return (grants.size() > k) ? grants[k] : -1;
  endfunction

  task automatic push_pkt(input int vc, input int len);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      f.d = FW'({$urandom(), $urandom()});
      f.h = (k == 0);
      f.t = (k == len - 1);
      fq[vc].push_back(f);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NV; i++) begin
      if (fq[i].size() > 0 && !bub[i]) begin
        vc_flit_valid[i] = 1'b1;
        vc_flit_head[i]  = fq[i][0].h;
        vc_flit_tail[i]  = fq[i][0].t;
        vc_flit_data[i*FW +: FW] = fq[i][0].d;
      end else begin
        vc_flit_valid[i] = 1'b0;
        vc_flit_head[i]  = 1'b0;
        vc_flit_tail[i]  = 1'b0;
        vc_flit_data[i*FW +: FW] = '0;
      end
    end
  endtask

  task automatic clear_stats();
    grants.delete();
    aborts_seen = 0;
    for (int i = 0; i < NV; i++) pops_seen[i] = 0;
  endtask

  // Called at posedge+1: drive, settle, compare against model, advance model, wait for next edge.
  task automatic cycle();
    bit e_val, e_tail, xfer, found;
    logic [FW-1:0] e_flit;
    logic [NV-1:0] e_pop;
    int v;
    drive();
    #1;
    e_val  = m_grant && vc_flit_valid[m_gvc];
    e_tail = m_grant && vc_flit_tail[m_gvc];
    e_flit = m_grant ? vc_flit_data[m_gvc*FW +: FW] : '0;
    xfer   = e_val && tx_ready;
    e_pop  = '0;
    if (xfer) e_pop[m_gvc] = 1'b1;
    chk("grant_active", grant_active, m_grant);
    chk("grant_vc", grant_vc, m_gvc);
    chk("tx_valid", tx_valid, e_val);
    chk("tx_tail", tx_tail, e_tail);
    chk("tx_flit", tx_flit, e_flit);
    chk("vc_pop", vc_pop, e_pop);
    chk("wdog_abort", wdog_abort, m_abort);
    if (grant_active && !prev_ga) grants.push_back(int'(grant_vc));
    prev_ga = grant_active;
    for (int i = 0; i < NV; i++) if (vc_pop[i]) pops_seen[i]++;
    if (wdog_abort) aborts_seen++;
    m_abort = 1'b0;
    if (m_grant) begin
      if (xfer) begin
        void'(fq[m_gvc].pop_front());
        m_stall = 0;
        if (e_tail) begin
          m_grant = 1'b0;
          m_ptr   = (m_gvc + 1) % NV;
        end
      end
`ifdef SNA_VC_ARB_WATCHDOG_EN
      else if (m_stall + 1 >= WD) begin
        m_grant = 1'b0;
        m_abort = 1'b1;
        m_ptr   = (m_gvc + 1) % NV;
      end else begin
        m_stall++;
      end
`endif
    end else if (tx_allocatable) begin
      found = 1'b0;
      for (int k = 0; k < NV; k++) begin
        v = (m_ptr + k) % NV;
        if (!found && vc_flit_valid[v] && vc_flit_head[v]) begin
          found   = 1'b1;
          m_grant = 1'b1;
          m_gvc   = v;
          m_stall = 0;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    for (int i = 0; i < NV; i++) begin
      fq[i].delete();
      bub[i] = 1'b0;
    end
    m_grant = 1'b0; m_abort = 1'b0; m_gvc = 0; m_ptr = 0; m_stall = 0;
    prev_ga = 1'b0;
    drive();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_grant_active", grant_active, 1'b0);
    chk("rst_grant_vc", grant_vc, 0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_flit", tx_flit, 0);
    chk("rst_vc_pop", vc_pop, 0);
    chk("rst_wdog_abort", wdog_abort, 1'b0);
    rst_n = 1'b1;
    clear_stats();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    int   exp_aborts;
    n_chk = 0; n_fail = 0;
    tx_allocatable = 1'b1; tx_ready = 1'b1;
    vc_flit_valid = '0; vc_flit_head = '0; vc_flit_tail = '0; vc_flit_data = '0;
    @(posedge clock); #1;

    // Pick from reset (pointer 0): valid/head masks, allocatable, expected grant one cycle later
    tbl[0] = '{8'h08, 8'h08, 1'b1, 1'b1, 3};
    tbl[1] = '{8'hFF, 8'h00, 1'b1, 1'b0, 0};
    tbl[2] = '{8'h0F, 8'hF0, 1'b1, 1'b0, 0};
    tbl[3] = '{8'hA0, 8'hFF, 1'b1, 1'b1, 5};
    tbl[4] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 0};
    tbl[5] = '{8'h81, 8'h81, 1'b1, 1'b1, 0};
    tbl[6] = '{8'h80, 8'h80, 1'b1, 1'b1, 7};
    tbl[7] = '{8'h6C, 8'h64, 1'b1, 1'b1, 2};
    for (int t = 0; t < 8; t++) begin
      reset_dut();
      vc_flit_valid  = tbl[t].v;
      vc_flit_head   = tbl[t].h;
      tx_allocatable = tbl[t].alloc;
      tx_ready       = 1'b0;
      @(posedge clock); #1;
      chk($sformatf("tbl%0d_active", t), grant_active, tbl[t].e_act);
      chk($sformatf("tbl%0d_vc", t), grant_vc, tbl[t].e_vc);
    end
    tx_allocatable = 1'b1; tx_ready = 1'b1;

    // Single VC 3-flit packet, then pointer must sit at 4
    reset_dut();
    push_pkt(3, 3);
    repeat (6) cycle();
    chk("single_grant", gnt(0), 3);
    chk("single_pops", pops_seen[3], 3);
    push_pkt(2, 1);
    push_pkt(5, 1);
    repeat (8) cycle();
    chk("single_next_ptr4", gnt(1), 5);
    chk("single_then_wrap", gnt(2), 2);

    // Fairness among VCs 0, 2, 5 with continuous 1-flit packets
    reset_dut();
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      foreach (fq[i]) if ((i == 0 || i == 2 || i == 5) && fq[i].size() == 0) push_pkt(i, 1);
      cycle();
    end
    chk("fair0", gnt(0), 0);
    chk("fair1", gnt(1), 2);
    chk("fair2", gnt(2), 5);
    chk("fair3", gnt(3), 0);

    // Backpressure on a 2-flit packet on VC 1
    reset_dut();
    push_pkt(1, 2);
    tx_ready = 1'b1; cycle();
    foreach (tbl[i]) begin end
    tx_ready = 1'b1; cycle();
    tx_ready = 1'b0; cycle();
    tx_ready = 1'b0; cycle();
    tx_ready = 1'b1; cycle();
    tx_ready = 1'b1; cycle();
    chk("bp_pops", pops_seen[1], 2);
    chk("bp_idle", grant_active, 1'b0);

    // No interleave: VC 2 head appears mid-packet on VC 6
    reset_dut();
    push_pkt(6, 3);
    cycle(); cycle();
    push_pkt(2, 2);
    for (int c = 0; c < 16; c++) begin
      tx_ready = c[0];
      cycle();
    end
    tx_ready = 1'b1;
    chk("ilv_first", gnt(0), 6);
    chk("ilv_second", gnt(1), 2);
    chk("ilv_pops2", pops_seen[2], 2);

    // Reset mid-packet on VC 4, then pointer must be back to 0
    reset_dut();
    push_pkt(4, 4);
    cycle(); cycle();
    chk("mid_pop_first", pops_seen[4], 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_active", grant_active, 1'b0);
    chk("mid_rst_pop", vc_pop, 0);
    chk("mid_rst_valid", tx_valid, 1'b0);
    chk("mid_rst_flit", tx_flit, 0);
    chk("mid_rst_vc", grant_vc, 0);
    @(posedge clock); #1;
    reset_dut();
    push_pkt(1, 1);
    push_pkt(5, 1);
    repeat (3) cycle();
    chk("mid_rst_ptr0", gnt(0), 1);

    // Stall after head on VC 7: watchdog release if compiled in, otherwise held
    reset_dut();
    push_pkt(7, 2);
    cycle(); cycle();
    bub[7] = 1'b1;
    repeat (20) cycle();
`ifdef SNA_VC_ARB_WATCHDOG_EN
    exp_aborts = 1;
`else
    exp_aborts = 0;
`endif
    chk("wdog_aborts", aborts_seen, exp_aborts);
    chk("wdog_held", grant_active, exp_aborts == 0);

    // Randomized traffic
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      tx_ready       = ($urandom_range(3) != 0);
      tx_allocatable = ($urandom_range(4) != 0);
      for (int i = 0; i < NV; i++) begin
        bub[i] = ($urandom_range(5) == 0);
        if (fq[i].size() < 6 && $urandom_range(7) == 0) push_pkt(i, 1 + $urandom_range(3));
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
